// File: rtl/uart_print_arb_pkg.sv
// uart_print_arb_pkg: shared debug-print arbiter constants, state encoding and index-width helper.
package uart_print_arb_pkg;
  localparam int seq_dp_width = 16;
  localparam int ARB_NUM_REQ = 4;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_print_arb_rr_pick.sv
// rr_pick: rotate-priority encoder, searching upward from last+1 and wrapping.
module rr_pick
  import uart_print_arb_pkg::*;
#(
  parameter int N = ARB_NUM_REQ,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] j;
  always_comb begin
    onehot = '0;
    idx = '0;
    valid = 1'b0;
    j = '0;
    for (int i = 1; i <= N; i++) begin
      j = IW'((int'(last) + i) % N);
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx = j;
        onehot[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_print_arb.sv
// uart_print_arb: round-robin arbiter feeding the shared UART register-print channel.
// UART_ARB_PRIO0_EN: requester 0 becomes fixed-highest priority; the rest rotate.
module uart_print_arb
  import uart_print_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int DP_WIDTH = seq_dp_width
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [2*NUM_REQ-1:0]         i_reg,
  input  logic [DP_WIDTH*NUM_REQ-1:0]  i_data,
  output logic [NUM_REQ-1:0]           o_gnt,
  output logic                         o_tx_stb,
  output logic [1:0]                   o_tx_reg,
  output logic [DP_WIDTH-1:0]          o_tx_data,
  input  logic                         i_tx_busy,
  output logic                         o_busy,
  output logic [15:0]                  o_sent_cnt
);
  localparam int LW = idx_w(NUM_REQ);
  arb_state_t state, state_n;
  logic [LW-1:0] last, win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic win_valid, take, upd_last, first;
`ifdef UART_ARB_PRIO0_EN
  logic [NUM_REQ-1:0] m_oh;
  logic [LW-1:0] m_idx;
  logic m_valid;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(i_req & ~NUM_REQ'(1)), .last(last), .onehot(m_oh), .idx(m_idx), .valid(m_valid)
  );
  assign win_oh = i_req[0] ? NUM_REQ'(1) : m_oh;
  assign win_idx = i_req[0] ? '0 : m_idx;
  assign win_valid = i_req[0] | m_valid;
  assign upd_last = take & ~i_req[0];
`else
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(i_req), .last(last), .onehot(win_oh), .idx(win_idx), .valid(win_valid)
  );
  assign upd_last = take;
`endif
  // WAIT ignores busy on its first cycle: the channel raises busy one cycle after the strobe
  always_comb begin
    take = (state == ARB_IDLE) && !i_tx_busy && win_valid;
    o_gnt = take ? win_oh : '0;
    o_tx_stb = (state == ARB_ISSUE);
    o_busy = (state != ARB_IDLE);
    state_n = take ? ARB_ISSUE :
              (state == ARB_ISSUE) ? ARB_WAIT :
              (state == ARB_WAIT && !first && !i_tx_busy) ? ARB_IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      last <= LW'(NUM_REQ - 1);
      first <= 1'b0;
      o_tx_reg <= '0;
      o_tx_data <= '0;
      o_sent_cnt <= '0;
    end else begin
      state <= state_n;
      first <= (state == ARB_ISSUE);
      if (upd_last) last <= win_idx;
      if (take) begin
        o_tx_reg <= i_reg[win_idx*2 +: 2];
        o_tx_data <= i_data[win_idx*DP_WIDTH +: DP_WIDTH];
      end
      if (state == ARB_ISSUE) o_sent_cnt <= o_sent_cnt + 16'd1;
    end
  end
endmodule
